// File: rtl/regfile_pkg.sv
// Register-file geometry shared by the writeback arbiter and its users.
package regfile_pkg;
  localparam int REGFILE_ADDR_W   = 3;
  localparam int REGFILE_DATA_W   = 16;
  localparam int REGFILE_NUM_REGS = 2 ** REGFILE_ADDR_W;

  typedef logic [REGFILE_ADDR_W-1:0] rf_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, returning a one-hot grant and the matching index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_pointer,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_grant_valid
);

  // Scan in priority order starting at the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    int               w_pos;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    o_grant       = '0;
    o_grant_idx   = '0;
    o_grant_valid = 1'b0;
    w_found       = 1'b0;
    w_pos         = 0;
    w_idx         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = int'(i_pointer) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      w_idx = w_pos[IDX_W-1:0];
      if (i_enable && !w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
        o_grant_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with a RAW-hazard busy mask.
// Optional macro REGFILE_R0_PROTECT_EN makes register 0 unwritable (grants still handshake).
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REGFILE_ADDR_W,
  parameter int DATA_W  = REGFILE_DATA_W,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_hold,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_rf_write_enable,
  output logic [ADDR_W-1:0]         o_rf_write_addr,
  output logic [DATA_W-1:0]         o_rf_write_data,
  output logic [IDX_W-1:0]          o_grant_id,
  output logic [2**ADDR_W-1:0]      o_busy_mask
);

  logic [IDX_W-1:0]   r_ptr;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;
  logic [IDX_W-1:0]   r_gid;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_grant_valid;
  logic               w_arb_en;
  logic               w_write_ok;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [IDX_W-1:0]   w_ptr_next;

  assign w_arb_en = !i_hold && !i_rst;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_arb (
    .i_req        (i_req_valid),
    .i_pointer    (r_ptr),
    .i_enable     (w_arb_en),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_grant_valid(w_grant_valid)
  );

  assign w_sel_addr = i_req_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_sel_data = i_req_data[w_grant_idx*DATA_W +: DATA_W];
  assign w_ptr_next = (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

`ifdef REGFILE_R0_PROTECT_EN
  assign w_write_ok = w_grant_valid && (w_sel_addr != '0);
`else
  assign w_write_ok = w_grant_valid;
`endif

  // Registered write port; a suppressed r0 write still advances the pointer but leaves rf_* alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_gid  <= '0;
      r_ptr  <= '0;
    end else begin
      r_we <= w_write_ok;
      if (w_grant_valid) r_ptr <= w_ptr_next;
      if (w_write_ok) begin
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
        r_gid  <= w_grant_idx;
      end
    end
  end

  always_comb begin
    o_busy_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_req_valid[i]) o_busy_mask[i_req_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (r_we) o_busy_mask[r_addr] = 1'b1;
`ifdef REGFILE_R0_PROTECT_EN
    o_busy_mask[0] = 1'b0;
`endif
    if (i_rst) o_busy_mask = '0;
  end

  assign o_req_ready       = w_grant;
  assign o_rf_write_enable = r_we;
  assign o_rf_write_addr   = r_addr;
  assign o_rf_write_data   = r_data;
  assign o_grant_id        = r_gid;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural round-robin model.
module tb_regfile_write_arbiter;
  localparam int NUM_REQ  = 2;
  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      hold;
  logic [NUM_REQ-1:0]        valid;
  logic [ADDR_W-1:0]         reqAddr [NUM_REQ];
  logic [DATA_W-1:0]         reqData [NUM_REQ];
  logic [NUM_REQ*ADDR_W-1:0] addrFlat;
  logic [NUM_REQ*DATA_W-1:0] dataFlat;
  logic [NUM_REQ-1:0]        reqReady;
  logic                      rfWe;
  logic [ADDR_W-1:0]         rfAddr;
  logic [DATA_W-1:0]         rfData;
  logic [0:0]                grantId;
  logic [NUM_REGS-1:0]       busyMask;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  assign addrFlat = {reqAddr[1], reqAddr[0]};
  assign dataFlat = {reqData[1], reqData[0]};

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_hold           (hold),
    .i_req_valid      (valid),
    .i_req_addr       (addrFlat),
    .i_req_data       (dataFlat),
    .o_req_ready      (reqReady),
    .o_rf_write_enable(rfWe),
    .o_rf_write_addr  (rfAddr),
    .o_rf_write_data  (rfData),
    .o_grant_id       (grantId),
    .o_busy_mask      (busyMask)
  );

  // Attached register file: writes on the falling edge, reg[i]=i at start.
  logic [DATA_W-1:0] rf [NUM_REGS];
  initial begin
    for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i);
    forever begin
      @(negedge clk);
      if (rfWe === 1'b1) rf[rfAddr] <= rfData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int pickReq(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic bit writeAllowed(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_R0_PROTECT_EN
    return a != '0;
`else
    return 1'b1;
`endif
  endfunction

  // Behavioural model state: what the write port must show and what the register file must hold.
  int                mPtr;
  logic              mWe;
  logic [ADDR_W-1:0] mAddr;
  logic [DATA_W-1:0] mData;
  int                mGid;
  logic [DATA_W-1:0] mRf [NUM_REGS];

  function automatic logic [NUM_REGS-1:0] expBusy();
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (rst) return m;
    for (int i = 0; i < NUM_REQ; i++) if (valid[i] && writeAllowed(reqAddr[i])) m[reqAddr[i]] = 1'b1;
    if (mWe && writeAllowed(mAddr)) m[mAddr] = 1'b1;
    return m;
  endfunction

  initial begin
    int g;
    for (int i = 0; i < NUM_REGS; i++) mRf[i] = DATA_W'(i);
    mPtr = 0; mWe = 1'b0; mAddr = '0; mData = '0; mGid = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mWe = 1'b0; mAddr = '0; mData = '0; mGid = 0; mPtr = 0;
      end else begin
        g   = hold ? -1 : pickReq(valid, mPtr);
        mWe = 1'b0;
        if (g >= 0) begin
          mPtr = (g + 1) % NUM_REQ;
          if (writeAllowed(reqAddr[g])) begin
            mWe   = 1'b1;
            mAddr = reqAddr[g];
            mData = reqData[g];
            mGid  = g;
            mRf[mAddr] = mData;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    int g;
    logic [NUM_REQ-1:0] expReady;
    forever begin
      @(negedge clk);
      if (started) begin
        g = pickReq(valid, mPtr);
        expReady = (!rst && !hold && g >= 0) ? NUM_REQ'(1 << g) : '0;
        checkOutput("req_ready", 32'(reqReady), 32'(expReady));
        checkOutput("write_enable", 32'(rfWe), 32'(mWe));
        checkOutput("write_addr", 32'(rfAddr), 32'(mAddr));
        checkOutput("write_data", 32'(rfData), 32'(mData));
        checkOutput("grant_id", 32'(grantId), 32'(mGid));
        checkOutput("busy_mask", 32'(busyMask), 32'(expBusy()));
        #1;
        for (int a = 0; a < NUM_REGS; a++) checkOutput("regfile", 32'(rf[a]), 32'(mRf[a]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    valid[i]   = v;
    reqAddr[i] = a;
    reqData[i] = d;
  endtask

  // One random cycle: requesters keep their request until granted, then may issue a new one.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] lastRdy);
    rst  = ($urandom_range(0, 299) == 0);
    hold = ($urandom_range(0, 99) < 20);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!valid[i] || lastRdy[i]) begin
        valid[i]   = ($urandom_range(0, 99) < 65);
        reqAddr[i] = ADDR_W'($urandom_range(0, NUM_REGS - 1));
        reqData[i] = DATA_W'($urandom);
      end
    end
  endtask

  initial begin
    int gidLog[$];
    int expSeq[6] = '{0, 1, 0, 1, 0, 1};
    logic [NUM_REQ-1:0] cap;

    rst = 1'b1; hold = 1'b0;
    setReq(0, 1'b1, 3'd1, 16'd11);
    setReq(1, 1'b1, 3'd2, 16'd22);
    @(posedge clk); #1;
    started = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", 32'(reqReady), 32'd0);
    checkOutput("reset_we", 32'(rfWe), 32'd0);
    checkOutput("reset_busy", 32'(busyMask), 32'd0);
    checkOutput("reset_gid", 32'(grantId), 32'd0);
    tick();
    rst = 1'b0;
    valid = '0;

    // Single write followed by an idle bubble.
    setReq(0, 1'b1, 3'd3, 16'd75);
    @(negedge clk);
    checkOutput("single_ready", 32'(reqReady), 32'd1);
    tick();
    valid = '0;
    @(negedge clk);
    checkOutput("single_we", 32'(rfWe), 32'd1);
    checkOutput("single_addr", 32'(rfAddr), 32'd3);
    checkOutput("single_data", 32'(rfData), 32'd75);
    checkOutput("single_gid", 32'(grantId), 32'd0);
    #1 checkOutput("single_reg3", 32'(rf[3]), 32'd75);
    tick();
    @(negedge clk);
    checkOutput("bubble_we", 32'(rfWe), 32'd0);
    checkOutput("bubble_addr", 32'(rfAddr), 32'd3);
    checkOutput("bubble_data", 32'(rfData), 32'd75);

    // Same-address conflict right after reset.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    setReq(0, 1'b1, 3'd4, 16'd175);
    setReq(1, 1'b1, 3'd4, 16'd215);
    @(negedge clk);
    checkOutput("conflict_ready0", 32'(reqReady), 32'd1);
    tick();
    valid[0] = 1'b0;
    @(negedge clk);
    checkOutput("conflict_ready1", 32'(reqReady), 32'd2);
    checkOutput("conflict_data0", 32'(rfData), 32'd175);
    tick();
    valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("conflict_data1", 32'(rfData), 32'd215);
    checkOutput("conflict_gid1", 32'(grantId), 32'd1);
    #1 checkOutput("conflict_reg4", 32'(rf[4]), 32'd215);

    // Fairness with both requesters continuously valid.
    tick();
    setReq(0, 1'b1, 3'd1, 16'd100);
    setReq(1, 1'b1, 3'd2, 16'd200);
    @(negedge clk);
    cap = reqReady;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++) if (cap[i]) reqData[i] = reqData[i] + 16'd1;
      @(negedge clk);
      gidLog.push_back(int'(grantId));
      cap = reqReady;
    end
    tick();
    valid[0] = 1'b0;
    tick();
    valid[1] = 1'b0;
    for (int k = 0; k < 6; k++) checkOutput("fair_seq", 32'(gidLog[k]), 32'(expSeq[k]));

    // Hold blocks new grants but keeps the request visible in busy_mask.
    tick();
    hold = 1'b1;
    setReq(1, 1'b1, 3'd5, 16'd33);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("hold_ready", 32'(reqReady), 32'd0);
      checkOutput("hold_we", 32'(rfWe), 32'd0);
      checkOutput("hold_busy5", 32'(busyMask[5]), 32'd1);
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    checkOutput("release_ready", 32'(reqReady), 32'd2);
    tick();
    valid[1] = 1'b0;
    @(negedge clk);
    checkOutput("release_we", 32'(rfWe), 32'd1);
    checkOutput("release_addr", 32'(rfAddr), 32'd5);
    checkOutput("release_busy5", 32'(busyMask[5]), 32'd1);
    tick();
    @(negedge clk);
    checkOutput("after_busy5", 32'(busyMask[5]), 32'd0);
    #1 checkOutput("hold_reg5", 32'(rf[5]), 32'd33);

    // Reset while a write is on the port; pointer must return to requester 0.
    tick();
    setReq(0, 1'b1, 3'd6, 16'd77);
    @(negedge clk);
    checkOutput("midrst_ready", 32'(reqReady), 32'd1);
    tick();
    valid[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_inflight", 32'(rfWe), 32'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_we", 32'(rfWe), 32'd0);
    checkOutput("midrst_busy", 32'(busyMask), 32'd0);
    checkOutput("midrst_gid", 32'(grantId), 32'd0);
    tick();
    setReq(0, 1'b1, 3'd1, 16'd5);
    setReq(1, 1'b1, 3'd2, 16'd6);
    @(negedge clk);
    checkOutput("midrst_ptr", 32'(reqReady), 32'd1);
    tick();
    valid[0] = 1'b0;
    tick();
    valid[1] = 1'b0;

    // Write to register 0.
    tick();
    setReq(0, 1'b1, 3'd0, 16'd9);
    @(negedge clk);
    checkOutput("r0_ready", 32'(reqReady), 32'd1);
    tick();
    valid[0] = 1'b0;
    @(negedge clk);
`ifdef REGFILE_R0_PROTECT_EN
    checkOutput("r0_we", 32'(rfWe), 32'd0);
    #1 checkOutput("r0_reg", 32'(rf[0]), 32'd0);
`else
    checkOutput("r0_we", 32'(rfWe), 32'd1);
    #1 checkOutput("r0_reg", 32'(rf[0]), 32'd9);
`endif

    // Random traffic against the model.
    @(negedge clk);
    cap = reqReady;
    repeat (2000) begin
      tick();
      applyStimulus(cap);
      @(negedge clk);
      cap = reqReady;
    end
    tick();
    rst = 1'b0; hold = 1'b0; valid = '0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
